// File: rtl/contador_bcd_mod_param_pkg.sv
// Shared definitions for the parametrised BCD up/down counter:
// digit width, largest legal digit, the step-kind enum and a helper that
// converts an integer into a fixed-width packed BCD constant.
package contador_bcd_mod_param_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // One digit more than the widest counter, so 10**DIGITS (the largest
  // legal MOD) is still representable for the range compares.
  localparam int BCD_EXT_DIGITS = 5;
  localparam int BCD_EXT_W = BCD_W * BCD_EXT_DIGITS;

  // What the counter does in a given cycle, after priority resolution.
  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_UP,
    STEP_DOWN,
    STEP_LOAD
  } step_e;

  // Packs a non-negative integer as BCD, digit0 in [3:0].
  function automatic logic [BCD_EXT_W-1:0] to_bcd(input int value);
    logic [BCD_EXT_W-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < BCD_EXT_DIGITS; i++) begin
      r[BCD_W*i +: BCD_W] = BCD_W'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// One decimal digit of the counter's ripple chain: adds or subtracts one
// when asked and reports the carry (9 -> 0) or borrow (0 -> 9) to the next
// digit. Purely combinational; the top level owns the count register.
module bcd_digit_updown
  import contador_bcd_mod_param_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  input  logic             inc,
  input  logic             dec,
  output logic [BCD_W-1:0] digit_o,
  output logic             cout,
  output logic             bout
);

  // Next digit value and the carry/borrow handed to the next digit up.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    digit_o = digit_i;
    cout    = 1'b0;
    bout    = 1'b0;
    if (inc && !dec) begin
      if (digit_i >= BCD_MAX) begin
        digit_o = '0;
        cout    = 1'b1;
      end else begin
        digit_o = digit_i + 4'd1;
      end
    end else if (dec && !inc) begin
      if (digit_i == '0) begin
        digit_o = BCD_MAX;
        bout    = 1'b1;
      end else begin
        digit_o = digit_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/contador_bcd_mod_param.sv
// Parametrised up/down BCD counter with programmable modulus, rising-edge
// step inputs, validated parallel load and one-cycle carry/borrow/load-error
// pulses for cascading (SS -> MM -> HH).
// Optional build macro CONTADOR_SATURATE_EN: the count saturates at 0 and at
// the top value MOD-1 instead of wrapping, and carry_out/borrow_out stay low.
module contador_bcd_mod_param
  import contador_bcd_mod_param_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int MOD    = 60
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enUP,
  input  logic                  enDOWN,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_bcd,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  carry_out,
  output logic                  borrow_out,
  output logic                  load_err
);

  localparam int W   = BCD_W * DIGITS;
  localparam int PAD = BCD_EXT_W - W;

  localparam logic [BCD_EXT_W-1:0] MOD_FULL  = to_bcd(MOD);
  localparam logic [BCD_EXT_W-1:0] WRAP_FULL = to_bcd(MOD - 1);
  localparam logic [W-1:0]         WRAP_BCD  = WRAP_FULL[W-1:0];

  logic [W-1:0] count_q, count_d;
  logic         carry_q, carry_d;
  logic         borrow_q, borrow_d;
  logic         load_err_q, load_err_d;
  logic         en_up_q, en_up_d;
  logic         en_down_q, en_down_d;

  logic         up_tick, dn_tick;
  step_e        step;
  logic         step_up, step_dn;
  logic         digits_ok, load_ok;
  logic         count_illegal, at_max, at_zero;
  logic [W-1:0] chain_bcd;

  assign up_tick = enUP & ~en_up_q;
  assign dn_tick = enDOWN & ~en_down_q;

  // Priority: load beats ticks; simultaneous up and down ticks cancel.
  always_comb begin
    step = STEP_HOLD;
    if (load) begin
      step = STEP_LOAD;
    end else if (up_tick && !dn_tick) begin
      step = STEP_UP;
    end else if (dn_tick && !up_tick) begin
      step = STEP_DOWN;
    end
  end

  assign step_up = (step == STEP_UP);
  assign step_dn = (step == STEP_DOWN);

  // Load value must be valid BCD in every digit before the range compare,
  // since the compare on packed BCD only orders correctly for legal digits.
  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_bcd[BCD_W*i +: BCD_W] > BCD_MAX) begin
        digits_ok = 1'b0;
      end
    end
  end

  assign load_ok       = digits_ok && ({{PAD{1'b0}}, load_bcd} < MOD_FULL);
  assign count_illegal = ({{PAD{1'b0}}, count_q} >= MOD_FULL);
  assign at_max        = (count_q == WRAP_BCD);
  assign at_zero       = (count_q == '0);

  // Ripple chain of digits; each digit steps when the one below wraps.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic cin, bin, cout, bout;
    if (i == 0) begin : g_first
      assign cin = step_up;
      assign bin = step_dn;
    end else begin : g_next
      assign cin = g_digit[i-1].cout;
      assign bin = g_digit[i-1].bout;
    end
    bcd_digit_updown u_digit (
      .digit_i (count_q[BCD_W*i +: BCD_W]),
      .inc     (cin),
      .dec     (bin),
      .digit_o (chain_bcd[BCD_W*i +: BCD_W]),
      .cout    (cout),
      .bout    (bout)
    );
  end

  // Wrap cases are decided by the explicit compares against 0 and MOD-1,
  // so the carry/borrow leaving the top digit has no consumer.
  logic unused_msd;
  assign unused_msd = g_digit[DIGITS-1].cout | g_digit[DIGITS-1].bout;

  // Next count and pulses: load, then stepped chain value with the wrap
  // (or saturation) at the count range overriding the plain digit result.
  always_comb begin
    count_d    = count_q;
    carry_d    = 1'b0;
    borrow_d   = 1'b0;
    load_err_d = 1'b0;
    en_up_d    = enUP;
    en_down_d  = enDOWN;
    unique case (step)
      STEP_LOAD: begin
        if (load_ok) begin
          count_d = load_bcd;
        end else begin
          load_err_d = 1'b1;
        end
      end
      STEP_UP: begin
        if (count_illegal) begin
          count_d = '0;
        end else if (at_max) begin
`ifdef CONTADOR_SATURATE_EN
          count_d = count_q;
`else
          count_d = '0;
          carry_d = 1'b1;
`endif
        end else begin
          count_d = chain_bcd;
        end
      end
      STEP_DOWN: begin
        if (count_illegal) begin
          count_d = WRAP_BCD;
        end else if (at_zero) begin
`ifdef CONTADOR_SATURATE_EN
          count_d = count_q;
`else
          count_d  = WRAP_BCD;
          borrow_d = 1'b1;
`endif
        end else begin
          count_d = chain_bcd;
        end
      end
      default: begin
      end
    endcase
  end

  // State register; edge detectors preset to 1 so a level held through reset is not a step.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      count_q    <= '0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
      en_up_q    <= 1'b1;
      en_down_q  <= 1'b1;
    end else begin
      count_q    <= count_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      load_err_q <= load_err_d;
      en_up_q    <= en_up_d;
      en_down_q  <= en_down_d;
    end
  end

  assign count_bcd  = count_q;
  assign carry_out  = carry_q;
  assign borrow_out = borrow_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_contador_bcd_mod_param.sv
// Bench for contador_bcd_mod_param: a 2-digit MOD-60 instance and a
// 3-digit MOD-365 instance driven from vector tables, with expected
// results queued at drive time and popped one edge later.
module tb_contador_bcd_mod_param;

`ifdef CONTADOR_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic        rst_n;
    logic        up;
    logic        dn;
    logic        ld;
    logic [11:0] ld_bcd;
    logic [11:0] cnt;
    logic        c;
    logic        b;
    logic        e;
  } vec_t;

  logic clk;
  logic rst_a, up_a, dn_a, ld_a;
  logic [7:0] ld_bcd_a, cnt_a;
  logic c_a, b_a, e_a;
  logic rst_b, up_b, dn_b, ld_b;
  logic [11:0] ld_bcd_b, cnt_b;
  logic c_b, b_b, e_b;

  int total = 0;
  int bad   = 0;
  vec_t exp_q[$];
  vec_t va[42];
  vec_t vb[14];

  contador_bcd_mod_param #(.DIGITS(2), .MOD(60)) u_dut_a (
    .clk        (clk),
    .reset      (rst_a),
    .enUP       (up_a),
    .enDOWN     (dn_a),
    .load       (ld_a),
    .load_bcd   (ld_bcd_a),
    .count_bcd  (cnt_a),
    .carry_out  (c_a),
    .borrow_out (b_a),
    .load_err   (e_a)
  );

  contador_bcd_mod_param #(.DIGITS(3), .MOD(365)) u_dut_b (
    .clk        (clk),
    .reset      (rst_b),
    .enUP       (up_b),
    .enDOWN     (dn_b),
    .load       (ld_b),
    .load_bcd   (ld_bcd_b),
    .count_bcd  (cnt_b),
    .carry_out  (c_b),
    .borrow_out (b_b),
    .load_err   (e_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic vec_t mk(input bit r, input bit u, input bit d, input bit l,
                              input logic [11:0] lv, input logic [11:0] cnt,
                              input bit co, input bit bo, input bit er);
    vec_t v;
    v.rst_n = r;  v.up = u;  v.dn = d;  v.ld = l;  v.ld_bcd = lv;
    v.cnt = cnt;  v.c = co;  v.b = bo;  v.e = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got cnt=%h c=%b b=%b e=%b, want cnt=%h c=%b b=%b e=%b",
               name, act[14:3], act[2], act[1], act[0], exp[14:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic apply(input bit sel_b, input vec_t v, input string name);
    vec_t want;
    logic [14:0] got;
    if (!sel_b) begin
      rst_a = v.rst_n;  up_a = v.up;  dn_a = v.dn;  ld_a = v.ld;
      ld_bcd_a = v.ld_bcd[7:0];
    end else begin
      rst_b = v.rst_n;  up_b = v.up;  dn_b = v.dn;  ld_b = v.ld;
      ld_bcd_b = v.ld_bcd;
    end
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    if (!sel_b) got = {4'h0, cnt_a, c_a, b_a, e_a};
    else        got = {cnt_b, c_b, b_b, e_b};
    check(name, got, {want.cnt, want.c, want.b, want.e});
  endtask

  initial begin
    rst_a = 1'b0; up_a = 1'b0; dn_a = 1'b0; ld_a = 1'b0; ld_bcd_a = '0;
    rst_b = 1'b0; up_b = 1'b0; dn_b = 1'b0; ld_b = 1'b0; ld_bcd_b = '0;

    // 2-digit, MOD 60:          rst up dn ld  ld_bcd   count                   c     b     e
    // reset with enUP held high, release without a step
    va[0]  = mk(0, 1, 0, 0, 12'h000, 12'h000,                0,    0,    0);
    va[1]  = mk(0, 1, 0, 0, 12'h000, 12'h000,                0,    0,    0);
    va[2]  = mk(0, 1, 0, 0, 12'h000, 12'h000,                0,    0,    0);
    va[3]  = mk(1, 1, 0, 0, 12'h000, 12'h000,                0,    0,    0);
    va[4]  = mk(1, 0, 0, 0, 12'h000, 12'h000,                0,    0,    0);
    // up wrap 58 -> 59 -> 00 with one-cycle carry
    va[5]  = mk(1, 0, 0, 1, 12'h058, 12'h058,                0,    0,    0);
    va[6]  = mk(1, 0, 0, 0, 12'h000, 12'h058,                0,    0,    0);
    va[7]  = mk(1, 1, 0, 0, 12'h000, 12'h059,                0,    0,    0);
    va[8]  = mk(1, 0, 0, 0, 12'h000, 12'h059,                0,    0,    0);
    va[9]  = mk(1, 1, 0, 0, 12'h000, SAT ? 12'h059 : 12'h000, ~SAT, 0,    0);
    va[10] = mk(1, 0, 0, 0, 12'h000, SAT ? 12'h059 : 12'h000, 0,    0,    0);
    // BCD borrow 10 -> 09, down wrap 00 -> 59
    va[11] = mk(1, 0, 0, 1, 12'h010, 12'h010,                0,    0,    0);
    va[12] = mk(1, 0, 1, 0, 12'h000, 12'h009,                0,    0,    0);
    va[13] = mk(1, 0, 0, 0, 12'h000, 12'h009,                0,    0,    0);
    va[14] = mk(1, 0, 0, 1, 12'h000, 12'h000,                0,    0,    0);
    va[15] = mk(1, 0, 1, 0, 12'h000, SAT ? 12'h000 : 12'h059, 0,    ~SAT, 0);
    va[16] = mk(1, 0, 0, 0, 12'h000, SAT ? 12'h000 : 12'h059, 0,    0,    0);
    // simultaneous up and down at 25, held for 5 clocks
    va[17] = mk(1, 0, 0, 1, 12'h025, 12'h025,                0,    0,    0);
    va[18] = mk(1, 1, 1, 0, 12'h000, 12'h025,                0,    0,    0);
    va[19] = mk(1, 1, 1, 0, 12'h000, 12'h025,                0,    0,    0);
    va[20] = mk(1, 1, 1, 0, 12'h000, 12'h025,                0,    0,    0);
    va[21] = mk(1, 1, 1, 0, 12'h000, 12'h025,                0,    0,    0);
    va[22] = mk(1, 1, 1, 0, 12'h000, 12'h025,                0,    0,    0);
    va[23] = mk(1, 0, 0, 0, 12'h000, 12'h025,                0,    0,    0);
    va[24] = mk(1, 1, 0, 0, 12'h000, 12'h026,                0,    0,    0);
    va[25] = mk(1, 0, 0, 0, 12'h000, 12'h026,                0,    0,    0);
    // load accept / reject (out of range, non-BCD digit), load beats a tick
    va[26] = mk(1, 0, 0, 1, 12'h045, 12'h045,                0,    0,    0);
    va[27] = mk(1, 0, 0, 1, 12'h060, 12'h045,                0,    0,    1);
    va[28] = mk(1, 0, 0, 1, 12'h03A, 12'h045,                0,    0,    1);
    va[29] = mk(1, 0, 0, 0, 12'h000, 12'h045,                0,    0,    0);
    va[30] = mk(1, 1, 0, 1, 12'h012, 12'h012,                0,    0,    0);
    va[31] = mk(1, 1, 0, 0, 12'h000, 12'h012,                0,    0,    0);
    va[32] = mk(1, 0, 0, 0, 12'h000, 12'h012,                0,    0,    0);
    va[33] = mk(1, 0, 1, 0, 12'h000, 12'h011,                0,    0,    0);
    va[34] = mk(1, 0, 0, 0, 12'h000, 12'h011,                0,    0,    0);
    // reset on the same edge as an up tick at 59
    va[35] = mk(1, 0, 0, 1, 12'h059, 12'h059,                0,    0,    0);
    va[36] = mk(0, 1, 0, 0, 12'h000, 12'h000,                0,    0,    0);
    va[37] = mk(1, 0, 0, 0, 12'h000, 12'h000,                0,    0,    0);
    va[38] = mk(1, 1, 0, 0, 12'h000, 12'h001,                0,    0,    0);
    va[39] = mk(1, 0, 0, 0, 12'h000, 12'h001,                0,    0,    0);
    va[40] = mk(1, 0, 0, 1, 12'h099, 12'h001,                0,    0,    1);
    va[41] = mk(1, 0, 0, 0, 12'h000, 12'h001,                0,    0,    0);

    // 3-digit, MOD 365
    vb[0]  = mk(0, 0, 0, 0, 12'h000, 12'h000,                0,    0,    0);
    vb[1]  = mk(1, 0, 0, 0, 12'h000, 12'h000,                0,    0,    0);
    vb[2]  = mk(1, 0, 0, 1, 12'h363, 12'h363,                0,    0,    0);
    vb[3]  = mk(1, 1, 0, 0, 12'h000, 12'h364,                0,    0,    0);
    vb[4]  = mk(1, 0, 0, 0, 12'h000, 12'h364,                0,    0,    0);
    vb[5]  = mk(1, 1, 0, 0, 12'h000, SAT ? 12'h364 : 12'h000, ~SAT, 0,    0);
    vb[6]  = mk(1, 0, 0, 0, 12'h000, SAT ? 12'h364 : 12'h000, 0,    0,    0);
    vb[7]  = mk(1, 0, 0, 1, 12'h100, 12'h100,                0,    0,    0);
    vb[8]  = mk(1, 0, 1, 0, 12'h000, 12'h099,                0,    0,    0);
    vb[9]  = mk(1, 0, 0, 0, 12'h000, 12'h099,                0,    0,    0);
    vb[10] = mk(1, 0, 0, 1, 12'h365, 12'h099,                0,    0,    1);
    vb[11] = mk(1, 0, 0, 1, 12'h000, 12'h000,                0,    0,    0);
    vb[12] = mk(1, 0, 1, 0, 12'h000, SAT ? 12'h000 : 12'h364, 0,    ~SAT, 0);
    vb[13] = mk(1, 0, 0, 0, 12'h000, SAT ? 12'h000 : 12'h364, 0,    0,    0);

    for (int i = 0; i < 42; i++) begin
      apply(1'b0, va[i], $sformatf("mod60 row %0d", i));
    end
    for (int i = 0; i < 14; i++) begin
      apply(1'b1, vb[i], $sformatf("mod365 row %0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
